// File: rtl/hazard_fwd_if.sv
// Interface between the ID/EX pipeline control and the hazard/forwarding controller.
// The stall/flush counters exist only when HAZARD_PERF_EN is defined.
interface hazard_fwd_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             id_wr_en;
    logic [REG_W-1:0] id_dst;
    logic             id_is_load;
    logic             ex_branch_taken;

    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_bubble;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
`endif

    modport master (
`ifdef HAZARD_PERF_EN
        input  stall_cnt,
        input  flush_cnt,
`endif
        output id_valid,
        output id_rs,
        output id_rt,
        output id_uses_rs,
        output id_uses_rt,
        output id_wr_en,
        output id_dst,
        output id_is_load,
        output ex_branch_taken,
        input  pc_en,
        input  ifid_en,
        input  ifid_flush,
        input  idex_bubble,
        input  fwd_a_sel,
        input  fwd_b_sel
    );

    modport slave (
`ifdef HAZARD_PERF_EN
        output stall_cnt,
        output flush_cnt,
`endif
        input  id_valid,
        input  id_rs,
        input  id_rt,
        input  id_uses_rs,
        input  id_uses_rt,
        input  id_wr_en,
        input  id_dst,
        input  id_is_load,
        input  ex_branch_taken,
        output pc_en,
        output ifid_en,
        output ifid_flush,
        output idex_bubble,
        output fwd_a_sel,
        output fwd_b_sel
    );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection and operand forwarding for the 5-stage MIPS pipeline.
// Define HAZARD_PERF_EN to add saturating stall/flush event counters.
module hazard_fwd_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst,
    hazard_fwd_if.slave  bus
);

    typedef struct packed {
        logic             wr;
        logic [REG_W-1:0] dst;
        logic             load;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
    } ex_rec_t;

    typedef struct packed {
        logic             wr;
        logic [REG_W-1:0] dst;
        logic             load;
    } mem_rec_t;

    typedef struct packed {
        logic             wr;
        logic [REG_W-1:0] dst;
    } wb_rec_t;

    logic     vld_p0;
    logic     vld_p1;
    logic     vld_p2;
    ex_rec_t  ex_p0;
    mem_rec_t mem_p1;
    wb_rec_t  wb_p2;

    logic     ex_load_live;
    logic     id_reads_ex_dst;
    logic     load_use;
    logic     flush;
    logic     stall;
    logic     bubble;

    // Register 0 is hard-wired, so a write to it never produces a value.
    function automatic logic produces(
        input logic             vld,
        input logic             wr,
        input logic [REG_W-1:0] dst,
        input logic [REG_W-1:0] src
    );
        return vld & wr & (dst == src) & (dst != '0);
    endfunction

    // Youngest producer wins; a load still in MEM has no data yet, so it is skipped.
    function automatic logic [1:0] fwd_sel(
        input logic             ex_vld,
        input logic [REG_W-1:0] src,
        input logic             mem_vld,
        input mem_rec_t         mem,
        input logic             wb_vld,
        input wb_rec_t          wb
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (ex_vld) begin
            if (produces(mem_vld, mem.wr, mem.dst, src) && !mem.load)
                sel = 2'b10;
            else if (produces(wb_vld, wb.wr, wb.dst, src))
                sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        ex_load_live    = vld_p0 & ex_p0.load & ex_p0.wr & (ex_p0.dst != '0);
        id_reads_ex_dst = (bus.id_uses_rs & (bus.id_rs == ex_p0.dst)) |
                          (bus.id_uses_rt & (bus.id_rt == ex_p0.dst));
        flush           = bus.ex_branch_taken;
        load_use        = ex_load_live & bus.id_valid & id_reads_ex_dst & !flush;
        stall           = load_use;
        bubble          = stall | flush;
    end

    // Flush is tested first so a taken branch always overrides a stall.
    always_comb begin
        bus.pc_en       = 1'b1;
        bus.ifid_en     = 1'b1;
        bus.ifid_flush  = 1'b0;
        bus.idex_bubble = 1'b0;
        if (flush) begin
            bus.ifid_flush  = 1'b1;
            bus.idex_bubble = 1'b1;
        end else if (stall) begin
            bus.pc_en       = 1'b0;
            bus.ifid_en     = 1'b0;
            bus.idex_bubble = 1'b1;
        end
    end

    always_comb begin
        bus.fwd_a_sel = fwd_sel(vld_p0, ex_p0.rs, vld_p1, mem_p1, vld_p2, wb_p2);
        bus.fwd_b_sel = fwd_sel(vld_p0, ex_p0.rt, vld_p1, mem_p1, vld_p2, wb_p2);
    end

    // ID -> EX (p0), EX -> MEM (p1), MEM -> WB (p2): valid bits
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p0 <= bus.id_valid & !bubble;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    // ID -> EX (p0), EX -> MEM (p1), MEM -> WB (p2): record payloads
    always_ff @(posedge clk) begin
        ex_p0.wr   <= bus.id_wr_en;
        ex_p0.dst  <= bus.id_dst;
        ex_p0.load <= bus.id_is_load;
        ex_p0.rs   <= bus.id_rs;
        ex_p0.rt   <= bus.id_rt;
        mem_p1.wr   <= ex_p0.wr;
        mem_p1.dst  <= ex_p0.dst;
        mem_p1.load <= ex_p0.load;
        wb_p2.wr  <= mem_p1.wr;
        wb_p2.dst <= mem_p1.dst;
    end

`ifdef HAZARD_PERF_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + 1'b1;
    endfunction

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall)
                stall_cnt_q <= sat_inc(stall_cnt_q);
            if (flush)
                flush_cnt_q <= sat_inc(flush_cnt_q);
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
`endif

endmodule
